// File: rtl/alu_sequencer_if.sv
// Bus bundle between the ALU sequencer, its command source, its result
// consumer and the external ALU.
//
// Handshake rules (both channels): a transfer happens on a rising clk edge
// where valid and ready are both 1. The source holds valid and its payload
// until that edge. The sink may raise or drop ready at any time. On the
// result channel the sequencer also keeps the payload unchanged for as long
// as valid is high.
interface alu_sequencer_if;
  // command channel
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_op;
  logic [7:0] cmd_a;
  logic [7:0] cmd_b;
  logic       cmd_use_acc;
  // external ALU
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [4:0] alu_s;
  logic [7:0] alu_y;
  logic       alu_c;
  // result channel
  logic       res_valid;
  logic       res_ready;
  logic [7:0] res_data;
  logic       res_carry;
  logic       res_zero;
  logic       res_err;

  // sequencer side
  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_use_acc, alu_y, alu_c, res_ready,
    output cmd_ready, alu_a, alu_b, alu_s, res_valid, res_data, res_carry,
    output res_zero, res_err
  );

  // environment side: command source, result sink and ALU
  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_use_acc, alu_y, alu_c, res_ready,
    input  cmd_ready, alu_a, alu_b, alu_s, res_valid, res_data, res_carry,
    input  res_zero, res_err
  );
endinterface

// File: rtl/alu_sequencer.sv
// ALU sequencer: takes one command at a time, drives an external ALU with
// registered select and operand lines, waits SETTLE cycles, and then
// captures the ALU result into an 8-bit accumulator. The captured result is
// held on the result channel until the consumer takes it. Illegal opcodes
// leave the ALU lines alone and return an error result straight away.
module alu_sequencer #(
  parameter int SETTLE = 1  // cycles the ALU lines are stable before capture, 1..15
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_sequencer_if.slave   bus,
  output logic [1:0]       dbg_state_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] acc_q, acc_d;
  logic [7:0] alu_a_q, alu_a_d;
  logic [7:0] alu_b_q, alu_b_d;
  logic [4:0] alu_s_q, alu_s_d;
  logic       carry_q, carry_d;
  logic       zero_q, zero_d;
  logic       err_q, err_d;

  // Opcode to select lines; bit 0 of the result is s0, bit 4 is s4.
  function automatic logic [4:0] op_to_sel(input logic [3:0] op);
    logic [4:0] sel;
    sel = 5'b00000;
    case (op)
      4'd0:    sel = 5'b00000;
      4'd1:    sel = 5'b00001;
      4'd2:    sel = 5'b00010;
      4'd3:    sel = 5'b00011;
      4'd4:    sel = 5'b01100;
      4'd5:    sel = 5'b10100;
      4'd6:    sel = 5'b10000;
      4'd7:    sel = 5'b00100;
      4'd8:    sel = 5'b01000;
      default: sel = 5'b00000;
    endcase
    return sel;
  endfunction

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic and datapath updates; every register holds by default.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    alu_a_d = alu_a_q;
    alu_b_d = alu_b_q;
    alu_s_d = alu_s_q;
    carry_d = carry_q;
    zero_d  = zero_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          if (bus.cmd_op <= 4'd8) begin
            alu_a_d = bus.cmd_use_acc ? acc_q : bus.cmd_a;
            alu_b_d = bus.cmd_b;
            alu_s_d = op_to_sel(bus.cmd_op);
            cnt_d   = 4'(SETTLE);
            state_d = ISSUE;
          end else begin
            // Illegal op: report against the untouched accumulator.
            err_d   = 1'b1;
            zero_d  = (acc_q == 8'h00);
            state_d = HOLD;
          end
        end
      end
      ISSUE: begin
        if (cnt_q == 4'd1) begin
          acc_d   = bus.alu_y;
          carry_d = bus.alu_c;
          zero_d  = (bus.alu_y == 8'h00);
          err_d   = 1'b0;
          cnt_d   = 4'd0;
          state_d = HOLD;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      HOLD: begin
        if (bus.res_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= 4'd0;
      acc_q   <= 8'h00;
      alu_a_q <= 8'h00;
      alu_b_q <= 8'h00;
      alu_s_q <= 5'b00000;
      carry_q <= 1'b0;
      zero_q  <= 1'b1;
      err_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      alu_a_q <= alu_a_d;
      alu_b_q <= alu_b_d;
      alu_s_q <= alu_s_d;
      carry_q <= carry_d;
      zero_q  <= zero_d;
      err_q   <= err_d;
    end
  end

  // cmd_ready is gated by rst_n so it reads 0 for the whole reset pulse.
  assign bus.cmd_ready = rst_n && (state_q == IDLE);
  assign bus.res_valid = (state_q == HOLD);
  assign bus.res_data  = acc_q;
  assign bus.res_carry = carry_q;
  assign bus.res_zero  = zero_q;
  assign bus.res_err   = err_q;
  assign bus.alu_a     = alu_a_q;
  assign bus.alu_b     = alu_b_q;
  assign bus.alu_s     = alu_s_q;
  assign dbg_state_o   = state_q;

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Parameter SETTLE, default 1, legal 1-15: number of clock cycles the ALU select/operand lines are held stable before the result is captured.
REQ-002 clk  input  1  single clock for the block; all state changes on the rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 cmd_valid  input  1  command present.
REQ-005 cmd_ready  output  1  block can accept a command.
REQ-006 cmd_op  input  4  operation code; 0-8 legal, 9-15 illegal.
REQ-007 cmd_a  input  8  operand A.
REQ-008 cmd_b  input  8  operand B.
REQ-009 cmd_use_acc  input  1  1 selects the accumulator as operand A instead of cmd_a.
REQ-010 alu_a, alu_b  output  8 each  operand lines to the external ALU.
REQ-011 alu_s  output  5  ALU select lines {s4,s3,s2,s1,s0}.
REQ-012 alu_y  input  8  ALU data result.
REQ-013 alu_c  input  1  ALU carry result.
REQ-014 res_valid  output  1  result held and valid.
REQ-015 res_ready  input  1  consumer accepts result.
REQ-016 res_data  output  8  captured result (equal to accumulator).
REQ-017 res_carry, res_zero, res_err  output  1 each  captured carry, result==0, illegal-op flag.

Function
REQ-018 States IDLE, ISSUE, HOLD; cmd_ready SHALL be 1 only in IDLE; res_valid SHALL be 1 only in HOLD.
REQ-019 IDLE: cmd_valid&cmd_ready at edge k with a legal op SHALL register alu_a/alu_b/alu_s, load settle counter with SETTLE, enter ISSUE.
REQ-020 Opcode-to-alu_s {s0,s1,s2,s3,s4}: 0=00000, 1=10000, 2=01000, 3=11000, 4=00110, 5=00101, 6=00001, 7=00100, 8=00010.
REQ-021 alu_a SHALL be the accumulator value at edge k when cmd_use_acc=1, else cmd_a; alu_b SHALL be cmd_b.
REQ-022 alu_a/alu_b/alu_s SHALL remain constant throughout ISSUE and HOLD, changing only on the next command acceptance or reset.
REQ-023 ISSUE: counter decrements each edge; at the edge where counter==1 the block SHALL latch alu_y into accumulator, alu_c into res_carry, (alu_y==0) into res_zero, clear res_err, enter HOLD.
REQ-024 Latency: with SETTLE=N, res_valid SHALL rise after edge k+N.
REQ-025 Illegal op (9-15) accepted at edge k: ALU lines unchanged, accumulator and res_carry unchanged, res_err=1, res_zero reflects unchanged accumulator, enter HOLD directly (res_valid after edge k).
REQ-026 HOLD: res_valid&res_ready at an edge SHALL return to IDLE; cmd_ready asserts in the following cycle (no same-cycle bypass).
REQ-027 res_data/res_carry/res_zero/res_err SHALL hold stable while res_valid=1 and res_ready=0, indefinitely.
REQ-028 cmd_valid in ISSUE or HOLD SHALL be ignored (not consumed); res_ready outside HOLD SHALL have no effect.
REQ-029 Accumulator arithmetic is 8-bit; no internal arithmetic beyond equality-to-zero; wrap-around is the ALU's responsibility.

Reset
REQ-030 rst_n low SHALL immediately force state IDLE, accumulator 0x00, res_data 0x00, alu_a 0x00, alu_b 0x00, alu_s 00000, res_carry 0, res_zero 1, res_err 0, res_valid 0, cmd_ready 0 while rst_n low.
REQ-031 Reset asserted during ISSUE or HOLD SHALL abort the operation with no result delivered; cmd_ready SHALL be 1 in the first cycle after rst_n deasserts.

Verification (bench ALU model: y=(a+b)[7:0], c=carry-out)
REQ-032 SETTLE=1, op 0, a=0xF8, b=0x1F -> alu_s=00000, res_valid after edge k+1, res_data=0x17, res_carry=1, res_zero=0.
REQ-033 Ops 0-8 in sequence -> alu_s matches REQ-020 table exactly for each, one result per command.
REQ-034 op 2, a=0x80, b=0x80, then op 1 with cmd_use_acc=1, a=0xFF, b=0x05 -> first res 0x00 carry=1 zero=1; second alu_a=0x00, res 0x05 carry=0.
REQ-035 op 12 -> res_err=1 after edge k, accumulator unchanged, alu_s unchanged.
REQ-036 SETTLE=3, res_ready held 0 for 10 cycles with cmd_valid=1 -> res_valid at edge k+3, outputs stable, no second command consumed until handshake.
REQ-037 rst_n pulsed low mid-ISSUE -> all outputs at reset values asynchronously, no res_valid, cmd_ready=1 after release.
